// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB types and constants for the completion-bus arbiter and its users.
`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 6
`endif
`ifndef CDB_NUM_REQ
`define CDB_NUM_REQ 3
`endif

package cdb_arbiter_pkg;

  localparam int unsigned RobTagLen = `ROB_TAG_LEN;
  localparam int unsigned CdbNumReq = `CDB_NUM_REQ;

  localparam int unsigned FU_ALU  = 0;
  localparam int unsigned FU_MULT = 1;
  localparam int unsigned FU_LSU  = 2;

  typedef struct packed {
    logic                 valid;
    logic [RobTagLen-1:0] rob_tag;
    logic [31:0]          value;
  } CDB_DATA;

endpackage

// File: rtl/cdb_arbiter_if.sv
// Functional-unit completion handshake plus the broadcast CDB.
interface cdb_arbiter_if
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = CdbNumReq
);
  logic [NUM_REQ-1:0]                fu_valid;
  logic [NUM_REQ-1:0][RobTagLen-1:0] fu_tag;
  logic [NUM_REQ-1:0][31:0]          fu_value;
  logic [NUM_REQ-1:0]                fu_grant;
  logic [NUM_REQ-1:0]                fu_stall;
  CDB_DATA                           cdb;

  // Arbiter side.
  modport master (
    input  fu_valid, fu_tag, fu_value,
    output fu_grant, fu_stall, cdb
  );

  // Functional-unit / consumer side.
  modport slave (
    output fu_valid, fu_tag, fu_value,
    input  fu_grant, fu_stall, cdb
  );
endinterface

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first requester at or after rr_ptr_i, modulo NUM_REQ.
module rr_priority_picker #(
  parameter int unsigned NUM_REQ = 3,
  localparam int unsigned PtrW   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PtrW-1:0]    rr_ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [PtrW-1:0]    idx_o,
  output logic               valid_o
);

  logic [PtrW-1:0] cand;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = PtrW'((32'(rr_ptr_i) + k) % NUM_REQ);
      if (!valid_o && req_i[cand]) begin
        grant_o[cand] = 1'b1;
        idx_o         = cand;
        valid_o       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing the single registered CDB among completing functional units.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = CdbNumReq
) (
  input logic           clk,
  input logic           reset,
  input logic           flush,
  cdb_arbiter_if.master bus
);

  localparam int unsigned PtrW = $clog2(NUM_REQ);

  logic [PtrW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [PtrW-1:0]    win_idx;
  logic [NUM_REQ-1:0] pick_grant;
  logic               pick_valid;
  logic               grant_valid;
  CDB_DATA            cdb_q, cdb_d;

  rr_priority_picker #(
    .NUM_REQ(NUM_REQ)
  ) u_picker (
    .req_i   (bus.fu_valid),
    .rr_ptr_i(rr_ptr_q),
    .grant_o (pick_grant),
    .idx_o   (win_idx),
    .valid_o (pick_valid)
  );

  // Flush suppresses the grant, so the losing units simply keep stalling.
  assign grant_valid  = pick_valid & ~flush;
  assign bus.fu_grant = grant_valid ? pick_grant : '0;
  assign bus.fu_stall = bus.fu_valid & ~bus.fu_grant;
  assign bus.cdb      = cdb_q;

  always_comb begin
    cdb_d       = cdb_q;
    cdb_d.valid = 1'b0;
    rr_ptr_d    = rr_ptr_q;
    if (grant_valid) begin
      cdb_d.valid   = 1'b1;
      cdb_d.rob_tag = bus.fu_tag[win_idx];
      cdb_d.value   = bus.fu_value[win_idx];
      rr_ptr_d      = (win_idx == PtrW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cdb_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      cdb_q    <= cdb_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: vector table plus CDB scoreboard queue.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int unsigned N = 3;

  logic clk = 1'b0;
  logic reset;
  logic flush;

  always #5 clk = ~clk;

  cdb_arbiter_if #(.NUM_REQ(N)) bus ();

  cdb_arbiter #(
    .NUM_REQ(N)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .flush(flush),
    .bus  (bus.master)
  );

  typedef struct {
    logic       fl;
    logic [2:0] v;
    logic [2:0] g;
    string      name;
  } vec_t;

  int                   checks = 0;
  int                   errors = 0;
  CDB_DATA              exp_q[$];
  logic [RobTagLen-1:0] tags[N];
  logic [31:0]          vals[N];
  vec_t                 vecs[15];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_data();
    for (int i = 0; i < N; i++) begin
      bus.fu_tag[i]   = tags[i];
      bus.fu_value[i] = vals[i];
    end
  endtask

  // One cycle: drive at negedge, check grant/stall, queue the expected broadcast,
  // then compare the registered CDB just after the following posedge.
  task automatic step(input logic fl, input logic [2:0] v, input logic [2:0] g,
                      input string name);
    CDB_DATA e;
    CDB_DATA got;
    @(negedge clk);
    flush        = fl;
    bus.fu_valid = v;
    drive_data();
    #1;
    check({name, "_grant"}, 64'(bus.fu_grant), 64'(g));
    check({name, "_stall"}, 64'(bus.fu_stall), 64'(v & ~g));
    e = '0;
    for (int i = 0; i < N; i++) begin
      if (g[i]) begin
        e.valid   = 1'b1;
        e.rob_tag = tags[i];
        e.value   = vals[i];
      end
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    flush = 1'b0;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_queue: got empty expected entry", name);
    end else begin
      e   = exp_q.pop_front();
      got = bus.cdb;
      check({name, "_cdb_valid"}, 64'(got.valid), 64'(e.valid));
      if (e.valid) begin
        check({name, "_cdb_tag"}, 64'(got.rob_tag), 64'(e.rob_tag));
        check({name, "_cdb_value"}, 64'(got.value), 64'(e.value));
      end
    end
  endtask

  task automatic check_cdb_reset(input string name);
    CDB_DATA got;
    got = bus.cdb;
    check({name, "_valid"}, 64'(got.valid), 64'd0);
    check({name, "_tag"}, 64'(got.rob_tag), 64'd0);
    check({name, "_value"}, 64'(got.value), 64'd0);
  endtask

  initial begin
    tags[FU_ALU]  = RobTagLen'(1);
    tags[FU_MULT] = RobTagLen'(5);
    tags[FU_LSU]  = RobTagLen'(3);
    vals[FU_ALU]  = 32'h0000_1111;
    vals[FU_MULT] = 32'h0000_DEAD;
    vals[FU_LSU]  = 32'h0000_3333;

    // Expected grants traced from rr_ptr = 0 after reset.
    vecs[0]  = '{1'b0, 3'b000, 3'b000, "idle0"};
    vecs[1]  = '{1'b0, 3'b000, 3'b000, "idle1"};
    vecs[2]  = '{1'b0, 3'b000, 3'b000, "idle2"};
    vecs[3]  = '{1'b0, 3'b010, 3'b010, "single_mult"};
    vecs[4]  = '{1'b0, 3'b101, 3'b100, "wrap_lsu"};
    vecs[5]  = '{1'b0, 3'b001, 3'b001, "wrap_alu"};
    vecs[6]  = '{1'b0, 3'b000, 3'b000, "idle3"};
    vecs[7]  = '{1'b0, 3'b100, 3'b100, "lsu_to_ptr0"};
    vecs[8]  = '{1'b0, 3'b111, 3'b001, "rr_alu"};
    vecs[9]  = '{1'b0, 3'b110, 3'b010, "rr_mult"};
    vecs[10] = '{1'b0, 3'b100, 3'b100, "rr_lsu"};
    vecs[11] = '{1'b0, 3'b111, 3'b001, "rr_alu_again"};
    vecs[12] = '{1'b1, 3'b011, 3'b000, "flush"};
    vecs[13] = '{1'b0, 3'b011, 3'b010, "post_flush"};
    vecs[14] = '{1'b0, 3'b111, 3'b100, "rr_lsu2"};

    reset        = 1'b1;
    flush        = 1'b0;
    bus.fu_valid = '0;
    drive_data();
    repeat (2) @(posedge clk);
    #1;
    check_cdb_reset("reset");
    reset = 1'b0;

    foreach (vecs[i]) step(vecs[i].fl, vecs[i].v, vecs[i].g, vecs[i].name);

    // Reset right after a grant with all units valid.
    step(1'b0, 3'b111, 3'b001, "pre_reset");
    @(negedge clk);
    reset        = 1'b1;
    bus.fu_valid = 3'b111;
    @(posedge clk);
    #1;
    check_cdb_reset("mid_reset");
    reset = 1'b0;
    step(1'b0, 3'b111, 3'b001, "post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Round-robin arbiter that shares the single common data bus (CDB) among the functional units completing out of the reservation stations. Each cycle it picks at most one pending result, grants the winning unit, and drives the result onto a registered CDB output that feeds reservation-station wakeup, the ROB and the map table. Units that lose arbitration are stalled and must hold their result until granted.

## Interface
Parameters:
- NUM_REQ, 3, number of requesting functional units (ALU, MULT, LSU); legal range 2..8.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  squash: drop the in-flight CDB broadcast and grant nothing this cycle.
- fu_valid  input  [NUM_REQ]  unit i holds a completed result.
- fu_tag  input  [NUM_REQ][`ROB_TAG_LEN]  destination ROB tag of unit i's result.
- fu_value  input  [NUM_REQ][32]  result value of unit i.
- fu_grant  output  [NUM_REQ]  one-hot or zero; unit i's result is accepted this cycle.
- fu_stall  output  [NUM_REQ]  fu_valid[i] & ~fu_grant[i]; drives the unit's exec_stall.
- cdb  output  CDB_DATA  registered broadcast {valid, rob_tag, value}.

## Operation
- State: rr_ptr (index of highest-priority requester, $clog2(NUM_REQ) bits), cdb register.
- Arbitration (combinational): scan i = rr_ptr, rr_ptr+1, ... modulo NUM_REQ; first i with fu_valid[i] wins. No requester → fu_grant = 0.
- Grant accepted when fu_valid[i] & fu_grant[i]; unit retires its result at that clock edge.
- On grant to i: cdb <= {1, fu_tag[i], fu_value[i]}; rr_ptr <= (i+1) mod NUM_REQ (wrap NUM_REQ-1 → 0).
- No grant: cdb.valid <= 0; rr_ptr unchanged. cdb.rob_tag/value hold previous value (don't-care when valid=0).
- flush: fu_grant forced 0 (fu_stall = fu_valid); cdb.valid <= 0; rr_ptr unchanged. flush overrides any request in the same cycle.
- Requester rule: once fu_valid[i] rises, fu_tag[i]/fu_value[i] stay stable until granted or flush. Tag 0 is reserved (means "ready/regfile" to reservation stations) and is never presented with fu_valid.
- Fairness: a continuously valid requester is granted within NUM_REQ cycles (no flush).

## Timing
- Reset values: cdb.valid=0, cdb.rob_tag=0, cdb.value=0, rr_ptr=0; fu_grant/fu_stall combinational from inputs (grant follows rr_ptr=0 in the first post-reset cycle).
- reset takes priority over flush and requests; reset mid-broadcast clears cdb.valid next edge.
- Latency: fu_valid in cycle t → fu_grant in cycle t (combinational) → cdb.valid in cycle t+1, exactly one cycle.
- Throughput: one result per cycle; back-to-back grants to different units produce back-to-back CDB broadcasts.
- Same unit may be granted on consecutive cycles only when no other unit is valid.
- No combinational path from fu_* to cdb.

## Structure
- Shared package: CDB_DATA (existing), `ROB_TAG_LEN (existing); add `CDB_NUM_REQ = 3 and FU index constants FU_ALU=0, FU_MULT=1, FU_LSU=2.
- Sub-module rr_priority_picker (NUM_REQ): inputs req vector + rr_ptr, outputs one-hot grant and winning index; purely combinational, reused by the dispatch stage.
- cdb_arbiter holds rr_ptr, the cdb register and the flush/reset gating.

## Test plan
- Reset, then fu_valid=3'b000 for 3 cycles → fu_grant=0, cdb.valid=0, rr_ptr=0 throughout.
- Single request: fu_valid[1]=1, tag=5, value=0xDEAD in cycle t → fu_grant=3'b010 in t, cdb={1,5,0xDEAD} in t+1, rr_ptr=2.
- All three valid and held, tags 1/2/3 → grants 0,1,2,0 in order; CDB shows tags 1,2,3 on consecutive cycles; each loser's fu_stall=1 until granted.
- Wrap-around: rr_ptr=2, fu_valid=3'b101 → unit 2 granted, rr_ptr → 0; next cycle unit 0 granted.
- Flush while fu_valid=3'b011 and cdb.valid=1 → fu_grant=0, fu_stall=3'b011, next cycle cdb.valid=0, rr_ptr unchanged.
- Reset asserted the cycle after a grant with all units valid → cdb.valid=0 and rr_ptr=0 next edge; first post-reset grant goes to unit 0.
